// File: rtl/cache_pkg.sv
// Shared cache types and default geometry used by the line-transfer engine
// and the cache controller.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } xfer_state_t;

    localparam int CACHE_WORD_WIDTH     = 32;
    localparam int CACHE_WORDS_PER_LINE = 8;
    localparam int CACHE_ADDR_WIDTH     = 32;

endpackage

// File: rtl/cache_line_addr_gen.sv
// Beat counter for one line transfer: produces the wrapped word index, the
// word-aligned beat address and a last-beat flag.
module cache_line_addr_gen
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = CACHE_ADDR_WIDTH,
    parameter int BYTE_BITS  = 2,
    parameter int LINE_BITS  = 3
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  i_load,
    input  logic                  i_advance,
    input  logic [LINE_BITS-1:0]  i_first_idx,
    input  logic [ADDR_WIDTH-1:0] i_base,
    output logic [LINE_BITS-1:0]  o_index,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_last
);

    logic [ADDR_WIDTH-1:0] r_base;
    logic [LINE_BITS-1:0]  r_first;
    logic [LINE_BITS-1:0]  r_beat;
    logic [LINE_BITS-1:0]  w_index;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_base  <= '0;
            r_first <= '0;
            r_beat  <= '0;
        end else if (i_load) begin
            r_base  <= i_base;
            r_first <= i_first_idx;
            r_beat  <= '0;
        end else if (i_advance) begin
            r_beat  <= r_beat + 1'b1;
        end
    end

    // LINE_BITS-wide sum wraps inside the line; the base has its offset bits
    // cleared, so OR-ing the index in can never carry into the tag.
    assign w_index    = r_first + r_beat;
    assign o_index    = w_index;
    assign o_mem_addr = r_base | (ADDR_WIDTH'(w_index) << BYTE_BITS);
    assign o_last     = &r_beat;

endmodule

// File: rtl/cache_line_xfer.sv
// Cache line fill / writeback engine over a req/ack word-wide memory port.
// Define CACHE_CWF_EN for critical-word-first beat ordering.
module cache_line_xfer
    import cache_pkg::*;
#(
    parameter int WORD_WIDTH     = CACHE_WORD_WIDTH,
    parameter int WORDS_PER_LINE = CACHE_WORDS_PER_LINE,
    parameter int ADDR_WIDTH     = CACHE_ADDR_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 clr_n,
    input  logic                                 start,
    input  logic                                 wr,
    input  logic [ADDR_WIDTH-1:0]                line_addr_i,
    input  logic [WORD_WIDTH*WORDS_PER_LINE-1:0] line_data_i,
    output logic [WORD_WIDTH*WORDS_PER_LINE-1:0] line_data_o,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 mem_req_o,
    output logic                                 mem_we_o,
    output logic [ADDR_WIDTH-1:0]                mem_addr_o,
    output logic [WORD_WIDTH-1:0]                mem_data_o,
    input  logic [WORD_WIDTH-1:0]                mem_data_i,
    input  logic                                 mem_ack_i
);

    localparam int BYTE_BITS = $clog2(WORD_WIDTH / 8);
    localparam int LINE_BITS = $clog2(WORDS_PER_LINE);
    localparam int OFF_BITS  = LINE_BITS + BYTE_BITS;

    xfer_state_t r_state;
    xfer_state_t w_next;

    logic                  r_wr;
    logic [WORD_WIDTH-1:0] r_buf [WORDS_PER_LINE];

    logic                  w_load;
    logic                  w_advance;
    logic                  w_last;
    logic [LINE_BITS-1:0]  w_index;
    logic [LINE_BITS-1:0]  w_first;
    logic [ADDR_WIDTH-1:0] w_base;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_unused_off;

    assign w_base       = {line_addr_i[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
    assign w_unused_off = ^line_addr_i[OFF_BITS-1:0];

`ifdef CACHE_CWF_EN
    assign w_first = line_addr_i[OFF_BITS-1:BYTE_BITS];
`else
    assign w_first = '0;
`endif

    cache_line_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BYTE_BITS  (BYTE_BITS),
        .LINE_BITS  (LINE_BITS)
    ) u_addr_gen (
        .clk         (clk),
        .clr_n       (clr_n),
        .i_load      (w_load),
        .i_advance   (w_advance),
        .i_first_idx (w_first),
        .i_base      (w_base),
        .o_index     (w_index),
        .o_mem_addr  (w_addr),
        .o_last      (w_last)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= IDLE;
            r_wr    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_wr <= wr;
            end
        end
    end

    // Request and beat address are held purely by staying in XFER with the
    // counter frozen until the memory acknowledges.
    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_advance = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        mem_req_o = 1'b0;
        mem_we_o  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = XFER;
                end
            end
            XFER: begin
                busy      = 1'b1;
                mem_req_o = 1'b1;
                mem_we_o  = r_wr;
                if (mem_ack_i) begin
                    w_advance = 1'b1;
                    if (w_last) begin
                        w_next = DONE;
                    end
                end
            end
            DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < WORDS_PER_LINE; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_load && wr) begin
            for (int i = 0; i < WORDS_PER_LINE; i++) begin
                r_buf[i] <= line_data_i[i*WORD_WIDTH +: WORD_WIDTH];
            end
        end else if (w_advance && !r_wr) begin
            r_buf[w_index] <= mem_data_i;
        end
    end

    assign mem_addr_o = w_addr;
    assign mem_data_o = r_buf[w_index];

    for (genvar g = 0; g < WORDS_PER_LINE; g++) begin : g_line_out
        assign line_data_o[g*WORD_WIDTH +: WORD_WIDTH] = r_buf[g];
    end

endmodule

// File: tb/tb_cache_line_xfer.sv
// Randomised self-checking bench for cache_line_xfer (default geometry).
module tb_cache_line_xfer;

    localparam int WW  = 32;
    localparam int WPL = 8;
    localparam int AW  = 32;
    localparam int LW  = WW * WPL;

    logic          clk = 1'b0;
    logic          clr_n = 1'b0;
    logic          start = 1'b0;
    logic          wr = 1'b0;
    logic [AW-1:0] line_addr_i = '0;
    logic [LW-1:0] line_data_i = '0;
    logic [LW-1:0] line_data_o;
    logic          busy, done, mem_req_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [WW-1:0] mem_data_o;
    logic [WW-1:0] mem_data_i = '0;
    logic          mem_ack_i = 1'b0;

    cache_line_xfer dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .start       (start),
        .wr          (wr),
        .line_addr_i (line_addr_i),
        .line_data_i (line_data_i),
        .line_data_o (line_data_o),
        .busy        (busy),
        .done        (done),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i),
        .mem_ack_i   (mem_ack_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [AW-1:0] addr;
        logic        we;
        logic [WW-1:0] wd;
        logic        ack;
    } samp_t;

    samp_t         sq[$];
    int            done_q[$];
    int            ack_mode = 0;
    int            req_n = 0;
    bit            pat_simple = 1'b0;
    logic [WW-1:0] salt = '0;
    int            n_tests = 0;
    int            n_fail = 0;

    // Memory contents as a pure function of the word address.
    function automatic logic [WW-1:0] mem_fn(input logic [AW-1:0] a);
        if (pat_simple) return 32'hA0 + WW'(a[4:2]);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    function automatic int first_idx(input logic [AW-1:0] a);
`ifdef CACHE_CWF_EN
        return int'(a[4:2]);
`else
        return 0;
`endif
    endfunction

    function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] a, input int k);
        int idx;
        idx = (first_idx(a) + k) % WPL;
        return (a & ~32'h1F) + AW'(idx * 4);
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int i = 0; i < WPL; i++) l[i*WW +: WW] = $urandom;
        return l;
    endfunction

    // Memory responder and bus logger; ack while idle is deliberately noisy.
    initial begin
        samp_t s;
        logic  a;
        forever begin
            @(negedge clk);
            if (mem_req_o) begin
                case (ack_mode)
                    0:       a = 1'b1;
                    1:       a = (req_n % 3 == 2);
                    default: a = 1'($urandom_range(0, 1));
                endcase
                req_n++;
                mem_ack_i  = a;
                mem_data_i = a ? mem_fn(mem_addr_o) : $urandom;
                s.cyc = cyc; s.addr = mem_addr_o; s.we = mem_we_o; s.wd = mem_data_o; s.ack = a;
                sq.push_back(s);
            end else begin
                mem_ack_i  = 1'($urandom_range(0, 1));
                mem_data_i = $urandom;
            end
            if (done) done_q.push_back(cyc);
        end
    end

    task automatic start_xfer(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] line, output int c0);
        @(negedge clk);
        sq.delete();
        done_q.delete();
        req_n = 0;
        start = 1'b1; wr = w; line_addr_i = a; line_data_i = line;
        c0 = cyc;
    endtask

    // policy 0: one-cycle start; 1: start held until done; 2: also pulse start in the done cycle
    task automatic wait_done(input int policy, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (policy != 1) start = 1'b0;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        start = ok && (policy == 2);
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_tests++; if ({busy, done, mem_req_o, mem_we_o} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b, required 0000", {busy, done, mem_req_o, mem_we_o}); end
        n_tests++; if (mem_addr_o !== '0) begin n_fail++; $display("FAIL reset_addr: got %h, required 0", mem_addr_o); end
        n_tests++; if (mem_data_o !== '0) begin n_fail++; $display("FAIL reset_wdata: got %h, required 0", mem_data_o); end
        n_tests++; if (line_data_o !== '0) begin n_fail++; $display("FAIL reset_line: got %h, required 0", line_data_o); end
        @(negedge clk);
        clr_n = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset busy: got %b, required 0", busy); end
    endtask

    task automatic test_fill(input int mode, input logic [AW-1:0] a, input bit simple);
        int            c0;
        bit            ok;
        samp_t         beats[$];
        logic [LW-1:0] exp_line;
        pat_simple = simple;
        salt       = $urandom;
        ack_mode   = mode;
        start_xfer(1'b0, a, rand_line(), c0);
        wait_done(0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL fill_done_timeout: addr %h, done=0, required 1", a); end
        n_tests++; if ({busy, mem_req_o} !== 2'b10) begin n_fail++; $display("FAIL fill_done_cycle busy/req: got %b, required 10", {busy, mem_req_o}); end
        foreach (sq[j]) if (sq[j].ack) beats.push_back(sq[j]);
        n_tests++; if (beats.size() != WPL) begin n_fail++; $display("FAIL fill_beats: got %0d, required %0d", beats.size(), WPL); end
        for (int k = 0; k < beats.size() && k < WPL; k++) begin
            n_tests++; if (beats[k].addr !== beat_addr(a, k)) begin n_fail++; $display("FAIL fill_addr[%0d]: got %h, required %h", k, beats[k].addr, beat_addr(a, k)); end
            n_tests++; if (beats[k].we !== 1'b0) begin n_fail++; $display("FAIL fill_we[%0d]: got %b, required 0", k, beats[k].we); end
            if (mode == 0) begin
                n_tests++; if (beats[k].cyc != c0 + 1 + k) begin n_fail++; $display("FAIL fill_beat_cycle[%0d]: got %0d, required %0d", k, beats[k].cyc - c0, 1 + k); end
            end
        end
        n_tests++; if (done_q.size() != 1) begin n_fail++; $display("FAIL fill_done_pulses: got %0d, required 1", done_q.size()); end
        if (mode == 0 && done_q.size() > 0) begin
            n_tests++; if (done_q[0] != c0 + WPL + 1) begin n_fail++; $display("FAIL fill_done_latency: got %0d, required %0d", done_q[0] - c0, WPL + 1); end
        end
        for (int i = 0; i < WPL; i++) exp_line[i*WW +: WW] = mem_fn((a & ~32'h1F) + AW'(i * 4));
        n_tests++; if (line_data_o !== exp_line) begin n_fail++; $display("FAIL fill_line: got %h, required %h", line_data_o, exp_line); end
        @(negedge clk);
        n_tests++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL fill_idle busy/done: got %b, required 00", {busy, done}); end
        n_tests++; if (line_data_o !== exp_line) begin n_fail++; $display("FAIL fill_line_stable: got %h, required %h", line_data_o, exp_line); end
    endtask

    task automatic test_fill_zero_wait();
        test_fill(0, 32'h0000_1234, 1'b1);
        for (int r = 0; r < 3; r++) test_fill(0, $urandom, 1'b0);
    endtask

    task automatic test_fill_wait_states();
        for (int r = 0; r < 4; r++) test_fill(2, $urandom, 1'b0);
    endtask

    task automatic test_writeback();
        int            c0;
        bit            ok;
        samp_t         beats[$];
        logic [LW-1:0] line;
        logic [AW-1:0] a;
        for (int r = 0; r < 3; r++) begin
            if (r == 0) for (int i = 0; i < WPL; i++) line[i*WW +: WW] = 32'h1111_1111 * i;
            else line = rand_line();
            a = $urandom;
            ack_mode = 1;
            beats.delete();
            start_xfer(1'b1, a, line, c0);
            wait_done(0, ok);
            n_tests++; if (!ok) begin n_fail++; $display("FAIL wb_done_timeout: done=0, required 1"); end
            n_tests++; if (sq.size() != 3 * WPL) begin n_fail++; $display("FAIL wb_req_cycles: got %0d, required %0d", sq.size(), 3 * WPL); end
            for (int j = 1; j < sq.size(); j++) begin
                if (!sq[j-1].ack) begin
                    n_tests++;
                    if ({sq[j].addr, sq[j].wd, sq[j].we} !== {sq[j-1].addr, sq[j-1].wd, sq[j-1].we}) begin
                        n_fail++; $display("FAIL wb_hold[%0d]: got %h/%h, required %h/%h", j, sq[j].addr, sq[j].wd, sq[j-1].addr, sq[j-1].wd);
                    end
                end
            end
            foreach (sq[j]) if (sq[j].ack) beats.push_back(sq[j]);
            n_tests++; if (beats.size() != WPL) begin n_fail++; $display("FAIL wb_beats: got %0d, required %0d", beats.size(), WPL); end
            for (int k = 0; k < beats.size() && k < WPL; k++) begin
                logic [AW-1:0] ea;
                ea = beat_addr(a, k);
                n_tests++; if (beats[k].addr !== ea) begin n_fail++; $display("FAIL wb_addr[%0d]: got %h, required %h", k, beats[k].addr, ea); end
                n_tests++; if (beats[k].wd !== line[ea[4:2]*WW +: WW]) begin n_fail++; $display("FAIL wb_data[%0d]: got %h, required %h", k, beats[k].wd, line[ea[4:2]*WW +: WW]); end
                n_tests++; if (beats[k].we !== 1'b1) begin n_fail++; $display("FAIL wb_we[%0d]: got %b, required 1", k, beats[k].we); end
            end
            n_tests++; if (done_q.size() != 1) begin n_fail++; $display("FAIL wb_done_pulses: got %0d, required 1", done_q.size()); end
            n_tests++; if (line_data_o !== line) begin n_fail++; $display("FAIL wb_line: got %h, required %h", line_data_o, line); end
        end
    endtask

    task automatic test_back_to_back();
        int c0, c1;
        bit ok;
        ack_mode = 2;
        pat_simple = 1'b0;
        start_xfer(1'b0, $urandom, rand_line(), c0);
        wait_done(1, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL held_start_timeout: done=0, required 1"); end
        n_tests++; if (sq.size() < WPL || done_q.size() != 1) begin n_fail++; $display("FAIL held_start_single: req cycles %0d, done pulses %0d, required >=%0d and 1", sq.size(), done_q.size(), WPL); end
        ack_mode = 0;
        start_xfer(1'b0, $urandom, rand_line(), c1);
        wait_done(2, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout: done=0, required 1"); end
        n_tests++; if (sq.size() == 0 || sq[0].cyc != c1 + 1) begin n_fail++; $display("FAIL b2b_start_latency: req cycles %0d, required first req 1 cycle after start", sq.size()); end
        n_tests++; if (done_q.size() != 1 || done_q[0] != c1 + WPL + 1) begin n_fail++; $display("FAIL b2b_done: pulses %0d, required 1 at +%0d", done_q.size(), WPL + 1); end
        @(negedge clk);
        start = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_in_done_ignored busy: got %b, required 0", busy); end
        sq.delete();
        done_q.delete();
        repeat (6) @(negedge clk);
        n_tests++; if (sq.size() != 0 || done_q.size() != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL start_in_done_quiet: req %0d done %0d busy %b, required 0 0 0", sq.size(), done_q.size(), busy); end
    endtask

    task automatic test_reset_mid();
        int c0;
        int acks;
        ack_mode = 0;
        start_xfer(1'b0, $urandom, rand_line(), c0);
        acks = 0;
        for (int i = 0; i < 50 && acks < 3; i++) begin
            @(negedge clk);
            start = 1'b0;
            acks = 0;
            foreach (sq[j]) if (sq[j].ack) acks++;
        end
        @(posedge clk);
        #2 clr_n = 1'b0;
        #1;
        n_tests++; if ({busy, done, mem_req_o, mem_we_o} !== 4'b0) begin n_fail++; $display("FAIL midrst_ctrl: got %b, required 0000", {busy, done, mem_req_o, mem_we_o}); end
        n_tests++; if (mem_addr_o !== '0 || mem_data_o !== '0) begin n_fail++; $display("FAIL midrst_bus: got %h/%h, required 0/0", mem_addr_o, mem_data_o); end
        n_tests++; if (line_data_o !== '0) begin n_fail++; $display("FAIL midrst_line: got %h, required 0", line_data_o); end
        @(negedge clk);
        clr_n = 1'b1;
        sq.delete();
        done_q.delete();
        repeat (12) @(negedge clk);
        n_tests++; if (sq.size() != 0 || done_q.size() != 0) begin n_fail++; $display("FAIL midrst_quiet: req %0d done %0d, required 0 0", sq.size(), done_q.size()); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_idle busy: got %b, required 0", busy); end
    endtask

    initial begin
        test_reset();
        test_fill_zero_wait();
        test_fill_wait_states();
        test_writeback();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
